mux4to1_rr_arb: RTL

- Four-channel to one-channel merge stage, the gathering counterpart of the 1-to-4 demux path.
- Accepts words from four independent valid/ready input channels.
- Picks one per cycle by round-robin arbitration and presents it on a single registered valid/ready output tagged with its 2-bit source select.
- Sits ahead of shared downstream logic, which can later re-split the stream by `out_sel`.

---
 rtl/mux4to1_rr_arb.sv | 96 +++++++++
 1 files changed

// File: rtl/mux4to1_rr_arb.sv
// Four-channel round-robin merge into one registered valid/ready output tagged with its source index.
// Grant is combinational from in_valid and the rotating pointer; a load happens whenever the output slot is empty or being drained.
module mux4to1_rr_arb #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            in_valid,
  input  logic [4*DATA_W-1:0]   in_data,
  output logic [3:0]            in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_sel,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      xfer_cnt
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_ptr;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_sel;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_any;
  logic [1:0]          w_grant;
  logic [1:0]          w_idx;
  logic                w_load_ok;
  logic [3:0]          w_ready;
  logic                w_xfer;

  // Scan from the farthest offset down so the channel nearest ptr wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = r_ptr;
    w_idx   = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (in_valid[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 4'b0000;
    w_load_ok   = (r_state == ST_EMPTY) || out_ready;
    if (w_load_ok && w_any && !rst) begin
      w_ready = 4'b0001 << w_grant;
    end
    w_xfer = |w_ready;
    case (r_state)
      ST_EMPTY: begin
        if (w_xfer) w_state_nxt = ST_FULL;
      end
      ST_FULL: begin
        if (w_xfer)         w_state_nxt = ST_FULL;
        else if (out_ready) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_ptr   <= 2'd0;
      r_data  <= '0;
      r_sel   <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_data <= in_data[w_grant*DATA_W +: DATA_W];
        r_sel  <= w_grant;
        r_ptr  <= w_grant + 2'd1;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign xfer_cnt  = r_cnt;

endmodule
